// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-stage predictions in order, checks each one
// against the resolved EX outcome, and produces predictor training, flush and
// redirect, plus branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int PC_LENGTH = 32,
  parameter int QDEPTH    = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid_i,
  input  logic [PC_LENGTH-1:0] fetch_pc_i,
  input  logic                 pred_taken_i,
  input  logic [PC_LENGTH-1:0] pred_target_i,
  output logic                 q_full_o,
  input  logic                 ex_valid_i,
  input  logic [PC_LENGTH-1:0] ex_pc_i,
  input  logic                 ex_is_bj_i,
  input  logic                 ex_taken_i,
  input  logic [PC_LENGTH-1:0] ex_target_i,
  output logic                 update_o,
  output logic                 taken_o,
  output logic [PC_LENGTH-1:0] pc_ex_o,
  output logic [PC_LENGTH-1:0] target_pc_o,
  output logic                 flush_o,
  output logic [PC_LENGTH-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]     br_cnt_o,
  output logic [CNT_W-1:0]     mispred_cnt_o,
  output logic                 err_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OCC_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [PC_LENGTH-1:0] pc;
    logic                 pred_taken;
    logic [PC_LENGTH-1:0] pred_target;
  } entry_t;

  entry_t           r_q [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_update;
  logic             r_taken;
  logic [PC_LENGTH-1:0] r_pc_ex;
  logic [PC_LENGTH-1:0] r_target_pc;
  logic             r_flush;
  logic [PC_LENGTH-1:0] r_redirect_pc;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic             r_err;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop_req;
  logic                 w_pop;
  logic                 w_pop_err;
  logic                 w_pc_err;
  logic                 w_push;
  logic                 w_push_err;
  logic                 w_mispred;
  logic                 w_bj_pop;
  logic [PC_LENGTH-1:0] w_correct_pc;
  entry_t               w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == OCC_W'(QDEPTH));
  assign q_full_o = w_full;
  assign w_head   = r_q[r_rd_ptr];

  // Pop/push qualification, mispredict detection and the correct-path PC.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block leaves a latch.
    w_mispred    = 1'b0;
    w_pc_err     = 1'b0;
    // The cycle after a flush is the drop window: pops ignored, pushes dropped.
    w_pop_req    = ex_valid_i && !r_flush;
    w_pop        = w_pop_req && !w_empty;
    w_pop_err    = w_pop_req && w_empty;
    w_bj_pop     = w_pop && ex_is_bj_i;
    w_correct_pc = (ex_is_bj_i && ex_taken_i) ? ex_target_i : ex_pc_i + PC_LENGTH'(4);
    if (w_pop) begin
      w_pc_err = (w_head.pc != ex_pc_i);
      if (ex_is_bj_i) begin
        w_mispred = (ex_taken_i != w_head.pred_taken) ||
                    (ex_taken_i && w_head.pred_taken && (ex_target_i != w_head.pred_target));
      end else begin
        w_mispred = w_head.pred_taken;
      end
    end
    // A push into a full queue is legal only when a pop frees the slot this cycle.
    w_push     = fetch_valid_i && !r_flush && (!w_full || w_pop) && !w_mispred;
    w_push_err = fetch_valid_i && !r_flush && w_full && !w_pop;
  end

  // Entry storage; contents are only read when the occupancy marks them valid.
  // NOTE: the entry array carries no reset -- stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= '{pc: fetch_pc_i, pred_taken: pred_taken_i, pred_target: pred_target_i};
  end

  // Pointers and occupancy; a mispredict discards everything in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_mispred) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered training, flush/redirect, statistics and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_update      <= 1'b0;
      r_taken       <= 1'b0;
      r_pc_ex       <= '0;
      r_target_pc   <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
      r_err         <= 1'b0;
    end else begin
      r_update <= w_bj_pop;
      if (w_bj_pop) begin
        r_taken     <= ex_taken_i;
        r_pc_ex     <= ex_pc_i;
        r_target_pc <= ex_target_i;
        r_br_cnt    <= r_br_cnt + CNT_W'(1);
      end
      r_flush <= w_mispred;
      if (w_mispred) begin
        r_redirect_pc <= w_correct_pc;
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
      r_err <= r_err || w_pop_err || w_push_err || w_pc_err;
    end
  end

  assign update_o      = r_update;
  assign taken_o       = r_taken;
  assign pc_ex_o       = r_pc_ex;
  assign target_pc_o   = r_target_pc;
  assign flush_o       = r_flush;
  assign redirect_pc_o = r_redirect_pc;
  assign br_cnt_o      = r_br_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based prediction model checked every
// cycle, plus hand-computed literal checks at key points of the directed sequence.
module tb_branch_resolve_unit;

  localparam int PCW    = 32;
  localparam int QDEPTH = 4;
  localparam int CNTW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_valid_i;
  logic [PCW-1:0]  fetch_pc_i;
  logic            pred_taken_i;
  logic [PCW-1:0]  pred_target_i;
  logic            q_full_o;
  logic            ex_valid_i;
  logic [PCW-1:0]  ex_pc_i;
  logic            ex_is_bj_i;
  logic            ex_taken_i;
  logic [PCW-1:0]  ex_target_i;
  logic            update_o;
  logic            taken_o;
  logic [PCW-1:0]  pc_ex_o;
  logic [PCW-1:0]  target_pc_o;
  logic            flush_o;
  logic [PCW-1:0]  redirect_pc_o;
  logic [CNTW-1:0] br_cnt_o;
  logic [CNTW-1:0] mispred_cnt_o;
  logic            err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_LENGTH(PCW), .QDEPTH(QDEPTH), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .q_full_o(q_full_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_is_bj_i(ex_is_bj_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .update_o(update_o), .taken_o(taken_o), .pc_ex_o(pc_ex_o),
    .target_pc_o(target_pc_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [PCW-1:0] pc;
    logic           t;
    logic [PCW-1:0] tg;
  } pred_t;

  pred_t          m_q[$];
  bit             m_valid = 0;
  logic           e_update, e_taken, e_flush, e_err;
  logic [PCW-1:0] e_pc_ex, e_target, e_redirect;
  logic [CNTW-1:0] e_br, e_mis;

  always @(posedge clk) begin
    pred_t h;
    bit drop, popped, mis;
    int size_before;
    if (!rst) begin
      m_q.delete();
      e_update = 0; e_taken = 0; e_flush = 0; e_err = 0;
      e_pc_ex = 0; e_target = 0; e_redirect = 0; e_br = 0; e_mis = 0;
    end else begin
      drop = e_flush;
      popped = 0;
      mis = 0;
      size_before = m_q.size();
      if (ex_valid_i && !drop) begin
        if (m_q.size() == 0) e_err = 1;
        else begin
          h = m_q.pop_front();
          popped = 1;
          if (h.pc != ex_pc_i) e_err = 1;
          if (ex_is_bj_i) mis = (ex_taken_i != h.t) || (ex_taken_i && ex_target_i != h.tg);
          else            mis = h.t;
        end
      end
      if (fetch_valid_i && !drop && !mis) begin
        if (size_before < QDEPTH || popped) m_q.push_back('{fetch_pc_i, pred_taken_i, pred_target_i});
        else e_err = 1;
      end
      if (mis) begin
        m_q.delete();
        e_redirect = (ex_is_bj_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
        e_mis++;
      end
      e_flush  = mis;
      e_update = popped && ex_is_bj_i;
      if (e_update) begin
        e_taken = ex_taken_i; e_pc_ex = ex_pc_i; e_target = ex_target_i; e_br++;
      end
    end
    m_valid = 1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("q_full",   q_full_o,      m_q.size() == QDEPTH);
      check("update",   update_o,      e_update);
      check("taken",    taken_o,       e_taken);
      check("pc_ex",    pc_ex_o,       e_pc_ex);
      check("target",   target_pc_o,   e_target);
      check("flush",    flush_o,       e_flush);
      check("redirect", redirect_pc_o, e_redirect);
      check("br_cnt",   br_cnt_o,      e_br);
      check("mis_cnt",  mispred_cnt_o, e_mis);
      check("err",      err_o,         e_err);
    end
  end

  // ---------------- stimulus ----------------
  // Drives one cycle of inputs (called at a negedge) and returns at the next
  // negedge, where the registered results of that cycle are visible.
  task automatic step(input logic fv, input logic [PCW-1:0] fpc, input logic pt, input logic [PCW-1:0] ptg,
                      input logic ev, input logic [PCW-1:0] epc, input logic bj, input logic tk,
                      input logic [PCW-1:0] tg);
    fetch_valid_i = fv; fetch_pc_i = fpc; pred_taken_i = pt; pred_target_i = ptg;
    ex_valid_i = ev; ex_pc_i = epc; ex_is_bj_i = bj; ex_taken_i = tk; ex_target_i = tg;
    @(negedge clk);
  endtask

  task automatic push(input logic [PCW-1:0] pc, input logic t, input logic [PCW-1:0] tg);
    step(1, pc, t, tg, 0, 0, 0, 0, 0);
  endtask

  task automatic pop(input logic [PCW-1:0] pc, input logic bj, input logic tk, input logic [PCW-1:0] tg);
    step(0, 0, 0, 0, 1, pc, bj, tk, tg);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0;
    fetch_valid_i = 0; fetch_pc_i = 0; pred_taken_i = 0; pred_target_i = 0;
    ex_valid_i = 0; ex_pc_i = 0; ex_is_bj_i = 0; ex_taken_i = 0; ex_target_i = 0;
    @(negedge clk);
    idle();
    rst = 1;
    check("lit_reset_flush", flush_o, 0);
    check("lit_reset_err", err_o, 0);
    check("lit_reset_br", br_cnt_o, 0);

    // In-order non-branch traffic.
    push(32'h100, 0, 0); push(32'h104, 0, 0); push(32'h108, 0, 0);
    pop(32'h100, 0, 0, 0); pop(32'h104, 0, 0, 0); pop(32'h108, 0, 0, 0);
    check("lit_nb_update", update_o, 0);
    check("lit_nb_flush", flush_o, 0);
    check("lit_nb_err", err_o, 0);

    // Correctly predicted taken branch.
    push(32'h200, 1, 32'h240);
    pop(32'h200, 1, 1, 32'h240);
    check("lit_ok_update", update_o, 1);
    check("lit_ok_taken", taken_o, 1);
    check("lit_ok_pc_ex", pc_ex_o, 32'h200);
    check("lit_ok_flush", flush_o, 0);
    check("lit_ok_br", br_cnt_o, 1);

    // Predicted not-taken, resolved taken; push in T and T+1 dropped, pop in T+1 ignored.
    push(32'h300, 0, 0);
    step(1, 32'h304, 0, 0, 1, 32'h300, 1, 1, 32'h380);
    check("lit_dir_flush", flush_o, 1);
    check("lit_dir_redirect", redirect_pc_o, 32'h380);
    check("lit_dir_mis", mispred_cnt_o, 1);
    step(1, 32'h308, 0, 0, 1, 32'h308, 0, 0, 0);
    check("lit_dir_flush_off", flush_o, 0);
    check("lit_dir_err", err_o, 0);

    // Wrong target.
    push(32'h500, 1, 32'h500);
    pop(32'h500, 1, 1, 32'h520);
    check("lit_tgt_redirect", redirect_pc_o, 32'h520);
    check("lit_tgt_target", target_pc_o, 32'h520);
    idle();

    // BTB alias on a non-branch.
    push(32'h600, 1, 32'h700);
    pop(32'h600, 0, 0, 0);
    check("lit_alias_flush", flush_o, 1);
    check("lit_alias_redirect", redirect_pc_o, 32'h604);
    check("lit_alias_update", update_o, 0);
    check("lit_alias_mis", mispred_cnt_o, 3);
    check("lit_alias_br", br_cnt_o, 3);
    idle();

    // Alias at the top of the address space: pc+4 wraps to 0.
    push(32'hFFFF_FFFC, 1, 32'h10);
    pop(32'hFFFF_FFFC, 0, 0, 0);
    check("lit_wrap_redirect", redirect_pc_o, 32'h0);
    idle();

    // Fill, simultaneous push/pop while full, wrap, overflow.
    push(32'h700, 0, 0); push(32'h704, 0, 0); push(32'h708, 0, 0); push(32'h70C, 0, 0);
    check("lit_full", q_full_o, 1);
    step(1, 32'h710, 0, 0, 1, 32'h700, 0, 0, 0);
    step(1, 32'h714, 0, 0, 1, 32'h704, 0, 0, 0);
    step(1, 32'h718, 0, 0, 1, 32'h708, 0, 0, 0);
    check("lit_full_pp", q_full_o, 1);
    check("lit_full_pp_err", err_o, 0);
    push(32'h71C, 0, 0);
    check("lit_overflow_err", err_o, 1);
    pop(32'h70C, 0, 0, 0); pop(32'h710, 0, 0, 0); pop(32'h714, 0, 0, 0); pop(32'h718, 0, 0, 0);
    check("lit_drained_full", q_full_o, 0);

    // Empty pop after a fresh reset.
    rst = 0; idle(); rst = 1;
    pop(32'h800, 1, 1, 32'h900);
    check("lit_empty_err", err_o, 1);
    check("lit_empty_flush", flush_o, 0);
    check("lit_empty_update", update_o, 0);

    // Reset with entries in flight.
    push(32'hA00, 1, 32'hA40); push(32'hA04, 0, 0);
    rst = 0; idle(); rst = 1;
    check("lit_rst_err", err_o, 0);
    check("lit_rst_full", q_full_o, 0);
    check("lit_rst_redirect", redirect_pc_o, 0);
    check("lit_rst_pc_ex", pc_ex_o, 0);
    check("lit_rst_mis", mispred_cnt_o, 0);
    // Stale entries must be gone: this push/pop pair sees only the new entry.
    push(32'hB00, 0, 0);
    pop(32'hB00, 0, 0, 0);
    check("lit_rst_after_err", err_o, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
